stdp_exp_sequencer: RTL and testbench

- STDP learning controller for one synapse.
- Sits directly upstream and downstream of the 9-bit exponential CORDIC unit.
- Measures pre/post spike time difference, converts it to x = -dt/tau in Q1.7, drives the exp unit's init/done interface, scales the returned exp(x) by the LTP/LTD amplitude, and applies the saturated update to the synaptic weight register.

---
 rtl/stdp_pkg.sv | 30 +++
 rtl/stdp_exp_sequencer_age.sv | 25 ++
 rtl/stdp_exp_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stdp_exp_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types and Q1.7 constants for the STDP exponential sequencer.
package stdp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_APPLY
    } state_t;

    typedef enum logic {
        DIR_LTP,
        DIR_LTD
    } dir_t;

    localparam logic signed [9:0] ONE   = 10'sd128;
    localparam logic signed [8:0] X_MIN = 9'sh100;

    // Negated magnitude as a Q1.7 argument; anything at or beyond 2.0 floors at -2.0.
    function automatic logic signed [8:0] neg_sat_x(input logic [31:0] mag);
        logic [8:0] m;
        m = mag[8:0];
        if (mag >= 32'd256) begin
            return X_MIN;
        end
        return signed'(9'(~m + 9'd1));
    endfunction

endpackage

// File: rtl/stdp_exp_sequencer_age.sv
// Saturating spike-age counter; the all-ones value marks the age as stale.
module spike_age_counter #(
    parameter int AGE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    output logic [AGE_W-1:0] age,
    output logic             stale
);

    assign stale = &age;

    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '1;
        end else if (clear) begin
            age <= '0;
        end else if (tick && !stale) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/stdp_exp_sequencer.sv
// STDP controller for one synapse around the 9-bit exponential CORDIC unit.
// Optional WAIT timeout guarded by STDP_EXP_TIMEOUT_EN.
module stdp_exp_sequencer
    import stdp_pkg::*;
#(
    parameter int AGE_W    = 8,
    parameter int DT_SHIFT = 3,
    parameter int W_W      = 8,
    parameter int W_MAX    = 255,
    parameter int A_PLUS   = 16,
    parameter int A_MINUS  = 12,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                pre_spike,
    input  logic                post_spike,
    input  logic                weight_load,
    input  logic [W_W-1:0]      weight_in,
    output logic [W_W-1:0]      weight_out,
    output logic                update_valid,
    output logic                busy,
    output logic                exp_init,
    output logic signed [8:0]   exp_x,
    input  logic signed [9:0]   exp_value,
`ifdef STDP_EXP_TIMEOUT_EN
    output logic                exp_timeout,
`endif
    input  logic                exp_done
);

    localparam logic [31:0] AMP_P = A_PLUS;
    localparam logic [31:0] AMP_M = A_MINUS;
    localparam logic [31:0] WMAX  = W_MAX;

    logic [AGE_W-1:0] pre_age, post_age;
    logic             pre_stale, post_stale;

    spike_age_counter #(.AGE_W(AGE_W)) u_pre_age (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clear (pre_spike),
        .age   (pre_age),
        .stale (pre_stale)
    );

    spike_age_counter #(.AGE_W(AGE_W)) u_post_age (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clear (post_spike),
        .age   (post_age),
        .stale (post_stale)
    );

    state_t           state;
    dir_t             dir;
    logic             ltp_pend, ltd_pend;
    logic [AGE_W-1:0] ltp_dt, ltd_dt;
    logic [8:0]       exp_cap;
    logic             ltp_event, ltd_event;
    logic [31:0]      delta, sum;
    logic [W_W-1:0]   w_next;

`ifdef STDP_EXP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign ltp_event = post_spike && !pre_spike && !pre_stale;
    assign ltd_event = pre_spike && !post_spike && !post_stale;

    // Scaled exp result and the saturated weight it would produce.
    always_comb begin
        delta  = (((dir == DIR_LTP) ? AMP_P : AMP_M) * {23'd0, exp_cap}) >> 7;
        sum    = 32'(weight_out) + delta;
        w_next = weight_out;
        if (dir == DIR_LTP) begin
            w_next = (sum > WMAX) ? W_W'(WMAX) : sum[W_W-1:0];
        end else begin
            w_next = (delta >= 32'(weight_out)) ? '0 : weight_out - delta[W_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            dir          <= DIR_LTP;
            ltp_pend     <= 1'b0;
            ltd_pend     <= 1'b0;
            ltp_dt       <= '0;
            ltd_dt       <= '0;
            exp_cap      <= '0;
            weight_out   <= '0;
            update_valid <= 1'b0;
            busy         <= 1'b0;
            exp_init     <= 1'b0;
            exp_x        <= '0;
`ifdef STDP_EXP_TIMEOUT_EN
            wait_cnt     <= '0;
            exp_timeout  <= 1'b0;
`endif
        end else begin
            update_valid <= 1'b0;
            exp_init     <= 1'b0;
            if (weight_load) begin
                weight_out <= weight_in;
            end
            case (state)
                S_IDLE: begin
                    if (ltp_pend) begin
                        dir      <= DIR_LTP;
                        exp_x    <= neg_sat_x(32'(ltp_dt) << DT_SHIFT);
                        ltp_pend <= 1'b0;
                        exp_init <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end else if (ltd_pend) begin
                        dir      <= DIR_LTD;
                        exp_x    <= neg_sat_x(32'(ltd_dt) << DT_SHIFT);
                        ltd_pend <= 1'b0;
                        exp_init <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_ARM;
                S_ARM: begin
`ifdef STDP_EXP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (exp_done) begin
                        exp_cap <= exp_value[9] ? 9'd0 : exp_value[8:0];
                        state   <= S_APPLY;
                    end
`ifdef STDP_EXP_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        exp_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                S_APPLY: begin
                    if (!weight_load) begin
                        weight_out   <= w_next;
                        update_valid <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
            // A fresh event must survive the same-cycle clear of its pending flag.
            if (ltp_event) begin
                ltp_pend <= 1'b1;
                ltp_dt   <= pre_age;
            end
            if (ltd_event) begin
                ltd_pend <= 1'b1;
                ltd_dt   <= post_age;
            end
        end
    end

endmodule

// File: tb/tb_stdp_exp_sequencer.sv
// Scoreboard bench for stdp_exp_sequencer with a 9-cycle exp unit model.
module tb_stdp_exp_sequencer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic              pre_spike = 1'b0;
    logic              post_spike = 1'b0;
    logic              weight_load = 1'b0;
    logic [7:0]        weight_in = 8'd0;
    logic [7:0]        weight_out;
    logic              update_valid;
    logic              busy;
    logic              exp_init;
    logic signed [8:0] exp_x;
    logic signed [9:0] exp_value = 10'sd0;
    logic              exp_done = 1'b1;
`ifdef STDP_EXP_TIMEOUT_EN
    logic              exp_timeout;
`endif

    int         checks = 0;
    int         errors = 0;
    int         init_cnt = 0;
    int         upd_cnt = 0;
    int         model_cnt = 0;
    logic       model_never = 1'b0;
    logic [9:0] model_val = 10'd0;
    int         x_q[$];
    int         w_q[$];

    stdp_exp_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .weight_load  (weight_load),
        .weight_in    (weight_in),
        .weight_out   (weight_out),
        .update_valid (update_valid),
        .busy         (busy),
        .exp_init     (exp_init),
        .exp_x        (exp_x),
        .exp_value    (exp_value),
`ifdef STDP_EXP_TIMEOUT_EN
        .exp_timeout  (exp_timeout),
`endif
        .exp_done     (exp_done)
    );

    always #5 clk = ~clk;

    // Exp unit model: done drops on init and rises 9 cycles later, otherwise it stays high.
    always @(posedge clk) begin
        if (exp_init) begin
            exp_done  <= 1'b0;
            model_cnt <= model_never ? 0 : 9;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) begin
                exp_done  <= 1'b1;
                exp_value <= signed'(model_val);
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_init) begin
                init_cnt++;
                if (x_q.size() == 0) checkOutput("unexpected_init", 1, 0);
                else checkOutput("exp_x", int'(exp_x), x_q.pop_front());
            end
            if (update_valid) begin
                upd_cnt++;
                if (w_q.size() == 0) checkOutput("unexpected_update", 1, 0);
                else checkOutput("weight_update", int'(weight_out), w_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic pre, input logic post, input logic tk,
                                 input logic ld, input logic [7:0] w);
        pre_spike   = pre;
        post_spike  = post;
        tick        = tk;
        weight_load = ld;
        weight_in   = w;
        @(negedge clk);
        pre_spike   = 1'b0;
        post_spike  = 1'b0;
        tick        = 1'b0;
        weight_load = 1'b0;
    endtask

    task automatic doTicks(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        x_q.delete();
        w_q.delete();
        init_cnt    = 0;
        upd_cnt     = 0;
        model_never = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((w_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", w_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitInit(input int target, input int budget);
        int n = 0;
        while (init_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("init_timeout", init_cnt, target);
    endtask

    initial begin
        @(negedge clk);
        doReset();
        checkOutput("rst_weight", int'(weight_out), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_init", int'(exp_init), 0);
        checkOutput("rst_valid", int'(update_valid), 0);
        checkOutput("rst_x", int'(exp_x), 0);
`ifdef STDP_EXP_TIMEOUT_EN
        checkOutput("rst_timeout", int'(exp_timeout), 0);
`endif

        // LTP: dt 4 -> x -32, exp 100 -> delta 12
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd100);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        doTicks(4);
        model_val = 10'd100;
        x_q.push_back(-32);
        w_q.push_back(112);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        waitDrain(60);
        checkOutput("ltp_weight", int'(weight_out), 112);
        checkOutput("ltp_updates", upd_cnt, 1);
        checkOutput("ltp_inits", init_cnt, 1);

        // LTD: dt 2 -> x -16, exp 113 -> delta 10
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd112);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        doTicks(2);
        model_val = 10'd113;
        x_q.push_back(-16);
        w_q.push_back(102);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        waitDrain(60);
        checkOutput("ltd_weight", int'(weight_out), 102);
        checkOutput("ltd_updates", upd_cnt, 1);

        // Saturation at both bounds with exp = 1.0
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd250);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        doTicks(1);
        model_val = 10'd128;
        x_q.push_back(-8);
        w_q.push_back(255);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        waitDrain(60);
        checkOutput("sat_high", int'(weight_out), 255);

        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        doTicks(1);
        x_q.push_back(-8);
        w_q.push_back(0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        waitDrain(60);
        checkOutput("sat_low", int'(weight_out), 0);

        // Stale and simultaneous spikes never start the exp unit
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (20) @(negedge clk);
        checkOutput("stale_post_inits", init_cnt, 0);
        checkOutput("stale_post_busy", int'(busy), 0);

        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (20) @(negedge clk);
        checkOutput("same_cycle_inits", init_cnt, 0);

        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        doTicks(255);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (20) @(negedge clk);
        checkOutput("aged_out_inits", init_cnt, 0);
        checkOutput("aged_out_updates", upd_cnt, 0);

        // Pending capture during WAIT: LTP (dt 0) then LTD (dt 0) follow the first op
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd100);
        model_val = 10'd128;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        doTicks(4);
        x_q.push_back(-32);
        w_q.push_back(116);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        waitInit(1, 20);
        repeat (4) @(negedge clk);
        checkOutput("prio_busy_in_wait", int'(busy), 1);
        x_q.push_back(0);
        w_q.push_back(132);
        x_q.push_back(0);
        w_q.push_back(120);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        waitDrain(120);
        checkOutput("prio_updates", upd_cnt, 3);
        checkOutput("prio_inits", init_cnt, 3);
        checkOutput("prio_weight", int'(weight_out), 120);

        // Reset during WAIT clears everything in one cycle
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd100);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        doTicks(1);
        x_q.push_back(-8);
        w_q.push_back(116);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        waitInit(1, 20);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_weight", int'(weight_out), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_init", int'(exp_init), 0);
        rst = 1'b0;
        x_q.delete();
        w_q.delete();
        init_cnt = 0;
        upd_cnt  = 0;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_restart", init_cnt, 0);

`ifdef STDP_EXP_TIMEOUT_EN
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd100);
        model_never = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        doTicks(1);
        x_q.push_back(-8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (40) @(negedge clk);
        checkOutput("timeout_flag", int'(exp_timeout), 1);
        checkOutput("timeout_weight", int'(weight_out), 100);
        checkOutput("timeout_busy", int'(busy), 0);
        checkOutput("timeout_updates", upd_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
